// File: rtl/comb_lock_pkg.sv
// Shared types, defaults and helpers for the parametrised combination lock.
// COMB_LOCK_REPROG_EN adds the PROG state and the reprogramming key.
package comb_lock_pkg;

  localparam int DEF_KEY_W    = 5;
  localparam int DEF_CODE_LEN = 4;
  localparam logic [DEF_CODE_LEN*DEF_KEY_W-1:0] DEF_CODE = {5'd3, 5'd1, 5'd4, 5'd1};

`ifdef COMB_LOCK_REPROG_EN
  // All-ones key; users slice it down to their key width.
  localparam logic [31:0] PROG_KEY = 32'hFFFF_FFFF;
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_LOCKOUT = 3'd3
`ifdef COMB_LOCK_REPROG_EN
    , S_PROG  = 3'd4
`endif
  } state_e;

  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; expired_o flags the last counted cycle.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == W'(1));

endmodule

// File: rtl/comb_lock_gen.sv
// Combination lock controller: code checking, failure lockout, entry timeout, open window.
// Define COMB_LOCK_REPROG_EN to allow reprogramming the code from the OPEN state.
module comb_lock_gen
  import comb_lock_pkg::*;
#(
  parameter int KEY_W       = DEF_KEY_W,
  parameter int CODE_LEN    = DEF_CODE_LEN,
  parameter logic [CODE_LEN*KEY_W-1:0] CODE = DEF_CODE,
  parameter int TIMEOUT_CYC = 50,
  parameter int OPEN_CYC    = 25,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 150
) (
  input  logic                           clk5,
  input  logic                           reset,
  input  logic                           newkey,
  input  logic [KEY_W-1:0]               keycode,
  output logic                           open,
  output logic [CODE_LEN-1:0]            led,
  output logic                           err,
  output logic                           lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]  fail_cnt
);

  localparam int TW = timer_width(TIMEOUT_CYC, OPEN_CYC, LOCKOUT_CYC);
  localparam int IW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] OPEN_V    = TW'(OPEN_CYC);
  localparam logic [TW-1:0] LOCKOUT_V = TW'(LOCKOUT_CYC);
  localparam logic [IW-1:0] LAST_IDX  = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_SAT  = FW'(MAX_FAIL);

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      mm_q, mm_d;
  logic [FW-1:0]             fail_q, fail_d;
  logic                      tLoad, tExpired;
  logic [TW-1:0]             tVal;
  logic                      errEv, doneEv;
  logic                      open_d, err_d, lockout_d, showIdx;
  logic [CODE_LEN-1:0]       led_d;
  logic [CODE_LEN*KEY_W-1:0] codeW;
  logic [KEY_W-1:0]          curDigit;
  logic                      keyWrong, mmNext;

`ifdef COMB_LOCK_REPROG_EN
  // New digits are staged so that an abandoned reprogramming leaves the code intact.
  logic [CODE_LEN*KEY_W-1:0] code_q, code_d, new_q, new_d;
  assign codeW = code_q;
`else
  assign codeW = CODE;
`endif

  lock_timer #(.W(TW)) uTimer (
    .clk_i      (clk5),
    .rst_i      (reset),
    .load_i     (tLoad),
    .load_val_i (tVal),
    .expired_o  (tExpired)
  );

  always_comb begin
    curDigit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx_q == IW'(i)) curDigit = codeW[(CODE_LEN-1-i)*KEY_W +: KEY_W];
    end
  end

  assign keyWrong = (keycode != curDigit);
  assign mmNext   = ((state_q == S_ENTRY) && mm_q) || keyWrong;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mm_d    = mm_q;
    fail_d  = fail_q;
    tLoad   = 1'b0;
    tVal    = TIMEOUT_V;
    errEv   = 1'b0;
    doneEv  = 1'b0;
`ifdef COMB_LOCK_REPROG_EN
    code_d  = code_q;
    new_d   = new_q;
`endif
    case (state_q)
      S_IDLE, S_ENTRY: begin
        if (newkey) begin
          tLoad = 1'b1;
          if (idx_q == LAST_IDX) begin
            doneEv = 1'b1;
            idx_d  = '0;
            mm_d   = 1'b0;
            if (!mmNext) begin
              state_d = S_OPEN;
              tVal    = OPEN_V;
              fail_d  = '0;
            end else begin
              errEv = 1'b1;
              if (int'(fail_q) + 1 < MAX_FAIL) begin
                state_d = S_IDLE;
                fail_d  = fail_q + 1'b1;
              end else begin
                state_d = S_LOCKOUT;
                tVal    = LOCKOUT_V;
                fail_d  = FAIL_SAT;
              end
            end
          end else begin
            state_d = S_ENTRY;
            idx_d   = idx_q + 1'b1;
            mm_d    = mmNext;
          end
        end else if ((state_q == S_ENTRY) && tExpired) begin
          state_d = S_IDLE;
          idx_d   = '0;
          mm_d    = 1'b0;
          errEv   = 1'b1;
        end
      end
      S_OPEN: begin
        if (tExpired) state_d = S_IDLE;
`ifdef COMB_LOCK_REPROG_EN
        if (newkey && (keycode == PROG_KEY[KEY_W-1:0])) begin
          state_d = S_PROG;
          idx_d   = '0;
          tLoad   = 1'b1;
        end
`endif
      end
      S_LOCKOUT: begin
        if (tExpired) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end
      end
`ifdef COMB_LOCK_REPROG_EN
      S_PROG: begin
        if (newkey) begin
          tLoad = 1'b1;
          for (int i = 0; i < CODE_LEN; i++) begin
            if (idx_q == IW'(i)) new_d[(CODE_LEN-1-i)*KEY_W +: KEY_W] = keycode;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
            code_d  = new_d;
            doneEv  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tExpired) begin
          state_d = S_IDLE;
          idx_d   = '0;
          errEv   = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // The completing key shows a full bar for one cycle before the LEDs clear.
  always_comb begin
    open_d    = (state_d == S_OPEN);
    lockout_d = (state_d == S_LOCKOUT);
    err_d     = errEv;
    showIdx   = (state_d == S_ENTRY);
`ifdef COMB_LOCK_REPROG_EN
    open_d    = open_d || (state_d == S_PROG);
    showIdx   = showIdx || (state_d == S_PROG);
`endif
    for (int i = 0; i < CODE_LEN; i++) begin
      led_d[i] = doneEv || (showIdx && (i < int'(idx_d)));
    end
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mm_q    <= 1'b0;
      fail_q  <= '0;
      open    <= 1'b0;
      led     <= '0;
      err     <= 1'b0;
      lockout <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mm_q    <= mm_d;
      fail_q  <= fail_d;
      open    <= open_d;
      led     <= led_d;
      err     <= err_d;
      lockout <= lockout_d;
    end
  end

`ifdef COMB_LOCK_REPROG_EN
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      code_q <= CODE;
      new_q  <= CODE;
    end else begin
      code_q <= code_d;
      new_q  <= new_d;
    end
  end
`endif

  assign fail_cnt = fail_q;

endmodule

// File: tb/tb_comb_lock_gen.sv
// Self-checking bench for comb_lock_gen: vector table, hand sequences and a random run
// against a key-queue reference model. Honours COMB_LOCK_REPROG_EN when defined.
module tb_comb_lock_gen;

  localparam int KEY_W       = 5;
  localparam int CODE_LEN    = 4;
  localparam int TIMEOUT_CYC = 50;
  localparam int OPEN_CYC    = 25;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 150;
  localparam int ALL_LED     = (1 << CODE_LEN) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_OPEN  = 2;
  localparam int M_LOCK  = 3;
  localparam int M_PROG  = 4;

  logic                clk5;
  logic                reset;
  logic                newkey;
  logic [KEY_W-1:0]    keycode;
  logic                open;
  logic [CODE_LEN-1:0] led;
  logic                err;
  logic                lockout;
  logic [1:0]          fail_cnt;

  comb_lock_gen #(
    .KEY_W       (KEY_W),
    .CODE_LEN    (CODE_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .OPEN_CYC    (OPEN_CYC),
    .MAX_FAIL    (MAX_FAIL),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk5     (clk5),
    .reset    (reset),
    .newkey   (newkey),
    .keycode  (keycode),
    .open     (open),
    .led      (led),
    .err      (err),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: keys collected in a queue and judged as a whole sequence.
  int mMode;
  int mKeys[$];
  int mIdle;
  int mLeft;
  int mFail;
  int mCode[CODE_LEN];
  int mLed;
  bit mOpen, mErr, mLock;

  function automatic void modelReset();
    mMode = M_IDLE;
    mKeys.delete();
    mIdle = 0;
    mLeft = 0;
    mFail = 0;
    mCode = '{3, 1, 4, 1};
    mLed  = 0;
    mOpen = 1'b0;
    mErr  = 1'b0;
    mLock = 1'b0;
  endfunction

  function automatic void modelJudge();
    bit match;
    match = 1'b1;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (mKeys[i] != mCode[i]) match = 1'b0;
    end
    mKeys.delete();
    if (match) begin
      mMode = M_OPEN;
      mLeft = OPEN_CYC;
      mFail = 0;
    end else begin
      mErr  = 1'b1;
      mFail = mFail + 1;
      if (mFail >= MAX_FAIL) begin
        mMode = M_LOCK;
        mLeft = LOCKOUT_CYC;
      end else begin
        mMode = M_IDLE;
      end
    end
  endfunction

  function automatic void modelStep(input bit nk, input int kc);
    bit done;
    bit progOn;
    done = 1'b0;
    mErr = 1'b0;
`ifdef COMB_LOCK_REPROG_EN
    progOn = 1'b1;
`else
    progOn = 1'b0;
`endif
    case (mMode)
      M_IDLE, M_ENTRY: begin
        if (nk) begin
          mKeys.push_back(kc);
          mIdle = 0;
          mMode = M_ENTRY;
          if (mKeys.size() == CODE_LEN) begin
            done = 1'b1;
            modelJudge();
          end
        end else if (mMode == M_ENTRY) begin
          mIdle++;
          if (mIdle == TIMEOUT_CYC) begin
            mMode = M_IDLE;
            mErr  = 1'b1;
            mKeys.delete();
          end
        end
      end
      M_OPEN: begin
        if (progOn && nk && kc == (1 << KEY_W) - 1) begin
          mMode = M_PROG;
          mKeys.delete();
          mIdle = 0;
        end else begin
          mLeft--;
          if (mLeft == 0) mMode = M_IDLE;
        end
      end
      M_LOCK: begin
        mLeft--;
        if (mLeft == 0) begin
          mMode = M_IDLE;
          mFail = 0;
        end
      end
      default: begin
        if (nk) begin
          mKeys.push_back(kc);
          mIdle = 0;
          if (mKeys.size() == CODE_LEN) begin
            for (int i = 0; i < CODE_LEN; i++) mCode[i] = mKeys[i];
            mKeys.delete();
            mMode = M_IDLE;
            done  = 1'b1;
          end
        end else begin
          mIdle++;
          if (mIdle == TIMEOUT_CYC) begin
            mMode = M_IDLE;
            mErr  = 1'b1;
            mKeys.delete();
          end
        end
      end
    endcase
    mOpen = (mMode == M_OPEN) || (mMode == M_PROG);
    mLock = (mMode == M_LOCK);
    if (done) mLed = ALL_LED;
    else if (mMode == M_ENTRY || mMode == M_PROG) mLed = (1 << mKeys.size()) - 1;
    else mLed = 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("open", int'(open), int'(mOpen));
    checkOutput("led", int'(led), mLed);
    checkOutput("err", int'(err), int'(mErr));
    checkOutput("lockout", int'(lockout), int'(mLock));
    checkOutput("fail_cnt", int'(fail_cnt), mFail);
  endtask

  // One clock: drive inputs, let the edge happen, then compare with the model.
  task automatic applyStimulus(input bit nk, input int kc);
    newkey  = nk;
    keycode = KEY_W'(kc);
    @(posedge clk5);
    modelStep(nk, kc);
    #1;
    compareAll();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 0);
  endtask

  task automatic sendCode(input int a, input int b, input int c, input int d);
    applyStimulus(1'b1, a);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, b);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, c);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, d);
  endtask

  task automatic applyReset(input string tag);
    reset   = 1'b1;
    newkey  = 1'b0;
    keycode = '0;
    #1;
    modelReset();
    checkOutput({tag, "_open"}, int'(open), 0);
    checkOutput({tag, "_led"}, int'(led), 0);
    checkOutput({tag, "_err"}, int'(err), 0);
    checkOutput({tag, "_lockout"}, int'(lockout), 0);
    checkOutput({tag, "_fail"}, int'(fail_cnt), 0);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    int k0, k1, k2, k3;
    int drain;
    int expOpen, expErr, expLock, expFail;
  } vec_t;

  vec_t vecs[5];
  int   pool[8];
  int   cnt;

  initial begin
    vecs[0] = '{k0:3, k1:1, k2:4, k3:1, drain:30, expOpen:1, expErr:0, expLock:0, expFail:0};
    vecs[1] = '{k0:3, k1:2, k2:4, k3:1, drain:3,  expOpen:0, expErr:1, expLock:0, expFail:1};
    vecs[2] = '{k0:3, k1:1, k2:4, k3:1, drain:30, expOpen:1, expErr:0, expLock:0, expFail:0};
    vecs[3] = '{k0:7, k1:7, k2:7, k3:7, drain:3,  expOpen:0, expErr:1, expLock:0, expFail:1};
    vecs[4] = '{k0:3, k1:1, k2:4, k3:2, drain:3,  expOpen:0, expErr:1, expLock:0, expFail:2};
    pool = '{3, 1, 4, 1, 7, 2, 31, 0};

    newkey  = 1'b0;
    keycode = '0;
    applyReset("rst0");

    for (int v = 0; v < 5; v++) begin
      sendCode(vecs[v].k0, vecs[v].k1, vecs[v].k2, vecs[v].k3);
      checkOutput($sformatf("vec%0d_open", v), int'(open), vecs[v].expOpen);
      checkOutput($sformatf("vec%0d_err", v), int'(err), vecs[v].expErr);
      checkOutput($sformatf("vec%0d_lockout", v), int'(lockout), vecs[v].expLock);
      checkOutput($sformatf("vec%0d_fail", v), int'(fail_cnt), vecs[v].expFail);
      checkOutput($sformatf("vec%0d_led", v), int'(led), ALL_LED);
      idle(vecs[v].drain);
    end

    // Correct code: LED bar steps and exact open window length.
    applyReset("rst1");
    applyStimulus(1'b1, 3);
    checkOutput("step_led1", int'(led), 1);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 1);
    checkOutput("step_led2", int'(led), 3);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 4);
    checkOutput("step_led3", int'(led), 7);
    applyStimulus(1'b0, 0);
    applyStimulus(1'b1, 1);
    checkOutput("step_led4", int'(led), 15);
    checkOutput("step_open_first", int'(open), 1);
    cnt = int'(open);
    for (int t = 0; t < 35; t++) begin
      applyStimulus(1'b0, 0);
      cnt += int'(open);
    end
    checkOutput("open_window_len", cnt, OPEN_CYC);

    // Lockout after three wrong codes; keys during lockout are ignored.
    applyReset("rst2");
    for (int r = 0; r < MAX_FAIL; r++) begin
      sendCode(0, 0, 0, 0);
      if (r < MAX_FAIL - 1) idle(3);
    end
    checkOutput("lock_enter", int'(lockout), 1);
    checkOutput("lock_fail", int'(fail_cnt), MAX_FAIL);
    cnt = int'(lockout);
    for (int t = 0; t < 170; t++) begin
      if (t < 140 && (t % 5) == 0) applyStimulus(1'b1, pool[(t / 5) % 4]);
      else applyStimulus(1'b0, 0);
      cnt += int'(lockout);
    end
    checkOutput("lock_len", cnt, LOCKOUT_CYC);
    checkOutput("lock_fail_clr", int'(fail_cnt), 0);
    sendCode(3, 1, 4, 1);
    checkOutput("lock_then_open", int'(open), 1);
    idle(30);

    // Entry timeout keeps the failure count; a key on the expiry cycle wins.
    applyReset("rst3");
    sendCode(3, 2, 4, 1);
    idle(2);
    applyStimulus(1'b1, 3);
    idle(TIMEOUT_CYC - 1);
    checkOutput("to_pre_err", int'(err), 0);
    checkOutput("to_pre_led", int'(led), 1);
    applyStimulus(1'b0, 0);
    checkOutput("to_err", int'(err), 1);
    checkOutput("to_led", int'(led), 0);
    checkOutput("to_fail", int'(fail_cnt), 1);
    applyStimulus(1'b1, 3);
    idle(TIMEOUT_CYC - 1);
    applyStimulus(1'b1, 1);
    checkOutput("edge_err", int'(err), 0);
    checkOutput("edge_led", int'(led), 3);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b1, 1);
    checkOutput("edge_open", int'(open), 1);
    checkOutput("edge_fail", int'(fail_cnt), 0);
    idle(30);

    // Asynchronous reset mid-entry and mid-open.
    applyStimulus(1'b1, 3);
    applyStimulus(1'b1, 1);
    applyReset("rst_entry");
    sendCode(3, 1, 4, 1);
    idle(5);
    applyReset("rst_open");

`ifdef COMB_LOCK_REPROG_EN
    sendCode(3, 1, 4, 1);
    idle(2);
    applyStimulus(1'b1, 31);
    checkOutput("prog_open_held", int'(open), 1);
    sendCode(7, 7, 7, 7);
    checkOutput("prog_done_open", int'(open), 0);
    idle(2);
    sendCode(7, 7, 7, 7);
    checkOutput("prog_new_open", int'(open), 1);
    idle(30);
    sendCode(3, 1, 4, 1);
    checkOutput("prog_old_open", int'(open), 0);
    checkOutput("prog_old_err", int'(err), 1);
    applyReset("rst_prog");
    sendCode(3, 1, 4, 1);
    checkOutput("prog_reset_open", int'(open), 1);
    idle(30);
`endif

    // Randomised bursts with varying key density to hit timeouts and lockouts.
    applyReset("rst_rand");
    for (int b = 0; b < 40; b++) begin
      int p;
      int len;
      p   = $urandom_range(1, 40);
      len = $urandom_range(20, 80);
      for (int t = 0; t < len; t++) begin
        bit nk;
        int kc;
        nk = ($urandom_range(0, p - 1) == 0);
        if ($urandom_range(0, 3) != 0) kc = pool[$urandom_range(0, 7)];
        else kc = $urandom_range(0, 31);
        applyStimulus(nk, kc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
